// File: rtl/ble_auth_rx.sv
// 8N1 UART receiver feeding the power-up authentication FSM of the BLE command path.
// 'G' arms pwr_up, 'S' requests power-down once the rider is off.
module ble_auth_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter logic [7:0]  CMD_GO   = 8'h47,
  parameter logic [7:0]  CMD_STOP = 8'h53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  // rx state  | meaning
  // RX_IDLE   | line idle, waiting for a synced falling edge
  // RX_START  | half-bit wait, confirm start bit is still low
  // RX_DATA   | sampling 8 data bits, LSB first
  // RX_STOP   | sampling stop bit, publish byte or flag framing error
  // auth state| meaning
  // AUTH_OFF  | not authorized, pwr_up low
  // AUTH_PWR1 | authorized by 'G'
  // AUTH_PWR2 | 'S' seen with rider on; drops as soon as rider_off rises
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR1, AUTH_PWR2} auth_state_t;

  // Counters reload with N-1 because the sample happens on the cycle they read zero.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_LOAD = 12'(BAUD_DIV - 1);

  rx_state_t   rx_state_q;
  auth_state_t auth_state_q, auth_state_d;

  logic        rx_meta_q, rx_sync_q, rx_hist_q;
  logic [11:0] baud_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_rdy_q, frm_err_q, pwr_up_q;
  logic        rx_fall, baud_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_hist_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_hist_q <= rx_sync_q;
    end
  end

  assign rx_fall   = rx_hist_q & ~rx_sync_q;
  assign baud_done = (baud_cnt_q == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      baud_cnt_q <= 12'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_rdy_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
            baud_cnt_q <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (baud_done) begin
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              baud_cnt_q <= FULL_LOAD;
              bit_cnt_q  <= 3'd0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 12'd1;
          end
        end
        RX_DATA: begin
          if (baud_done) begin
            shift_q    <= {rx_sync_q, shift_q[7:1]};
            baud_cnt_q <= FULL_LOAD;
            if (bit_cnt_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 12'd1;
          end
        end
        RX_STOP: begin
          if (baud_done) begin
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              rx_data_q <= shift_q;
              rx_rdy_q  <= 1'b1;
            end else begin
              frm_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 12'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // A received 'G' takes priority over the rider_off exit from PWR2.
  always_comb begin
    auth_state_d = auth_state_q;
    case (auth_state_q)
      AUTH_OFF: begin
        if (rx_rdy_q && rx_data_q == CMD_GO) auth_state_d = AUTH_PWR1;
      end
      AUTH_PWR1: begin
        if (rx_rdy_q && rx_data_q == CMD_STOP) begin
          auth_state_d = rider_off ? AUTH_OFF : AUTH_PWR2;
        end
      end
      AUTH_PWR2: begin
        if (rx_rdy_q && rx_data_q == CMD_GO) auth_state_d = AUTH_PWR1;
        else if (rider_off)                  auth_state_d = AUTH_OFF;
      end
      default: auth_state_d = AUTH_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_state_q <= AUTH_OFF;
      pwr_up_q     <= 1'b0;
    end else begin
      auth_state_q <= auth_state_d;
      pwr_up_q     <= (auth_state_d != AUTH_OFF);
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign frm_err = frm_err_q;
  assign pwr_up  = pwr_up_q;

endmodule
